// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN frame constants, FSM state encoding and CRC-15 step function.
package can_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_ID,
    ST_CTRL,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK,
    ST_ACK_DEL,
    ST_EOF
  } can_state_t;

  localparam int CAN_ID_LEN   = 11;
  localparam int CAN_CTRL_LEN = 3;
  localparam int CAN_DLC_LEN  = 5;
  localparam int CAN_DATA_LEN = 32;
  localparam int CAN_CRC_LEN  = 15;
  localparam int CAN_EOF_LEN  = 7;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? CAN_CRC_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial CRC-15 (CAN polynomial), one bit per enabled cycle; shared with can_tx.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        din,
  output logic [14:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc15_step(crc, din);
    end
  end

endmodule

// File: rtl/can_rx.sv
// rtl/can_rx.sv - CAN receiver for one fixed-format data frame with CRC check and ACK drive.
// Optional acceptance filter on the identifier when CAN_RX_ID_FILTER_EN is defined.
module can_rx
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11,
  parameter int DLC_VAL   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_tick,
  input  logic        rx,
`ifdef CAN_RX_ID_FILTER_EN
  input  logic [10:0] acc_id,
  input  logic [10:0] acc_mask,
`endif
  output logic        tx,
  output logic [10:0] rx_id,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        crc_err,
  output logic        form_err
);

  can_state_t  state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [10:0] id_sh;
  logic [31:0] data_sh;
  logic [4:0]  dlc_sh;
  logic [14:0] crc_rx;
  logic [14:0] crc_calc;
  logic        frame_ok, ok_nxt;
  logic        crc_en, crc_clr;
  logic        tx_nxt, valid_nxt, crc_err_nxt, form_err_nxt;
  logic        crc_match, id_pass;

  assign crc_match = (crc_rx == crc_calc);

`ifdef CAN_RX_ID_FILTER_EN
  assign id_pass = (((id_sh ^ acc_id) & acc_mask) == 11'h000);
`else
  assign id_pass = 1'b1;
`endif

  can_crc15 u_crc (
    .clk (clk),
    .rst (rst),
    .en  (crc_en),
    .clr (crc_clr),
    .din (rx),
    .crc (crc_calc)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    tx_nxt       = tx;
    ok_nxt       = frame_ok;
    valid_nxt    = 1'b0;
    crc_err_nxt  = 1'b0;
    form_err_nxt = 1'b0;
    crc_en       = 1'b0;
    crc_clr      = 1'b0;
    if (baud_tick) begin
      cnt_nxt = cnt + 6'd1;
      unique case (state)
        ST_WAIT_IDLE: begin
          crc_clr = 1'b1;
          if (!rx) cnt_nxt = 6'd0;
          else if (cnt == 6'(IDLE_BITS - 1)) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          // SOF is the first bit covered by the CRC
          if (!rx) begin
            crc_en    = 1'b1;
            state_nxt = ST_ID;
          end else begin
            crc_clr = 1'b1;
          end
        end
        ST_ID: begin
          crc_en = 1'b1;
          if (cnt == 6'(CAN_ID_LEN - 1)) state_nxt = ST_CTRL;
        end
        ST_CTRL: begin
          crc_en = 1'b1;
          if (rx) begin
            form_err_nxt = 1'b1;
            state_nxt    = ST_WAIT_IDLE;
          end else if (cnt == 6'(CAN_CTRL_LEN - 1)) begin
            state_nxt = ST_DLC;
          end
        end
        ST_DLC: begin
          crc_en = 1'b1;
          if (cnt == 6'(CAN_DLC_LEN - 1)) begin
            if ({rx, dlc_sh[4:1]} != 5'(DLC_VAL)) begin
              form_err_nxt = 1'b1;
              state_nxt    = ST_WAIT_IDLE;
            end else begin
              state_nxt = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          crc_en = 1'b1;
          if (cnt == 6'(CAN_DATA_LEN - 1)) state_nxt = ST_CRC;
        end
        ST_CRC: begin
          if (cnt == 6'(CAN_CRC_LEN - 1)) state_nxt = ST_CRC_DEL;
        end
        ST_CRC_DEL: begin
          crc_clr     = 1'b1;
          crc_err_nxt = !crc_match;
          ok_nxt      = crc_match && id_pass;
          if (!rx) begin
            form_err_nxt = 1'b1;
            state_nxt    = ST_WAIT_IDLE;
          end else begin
            tx_nxt    = !(crc_match && id_pass);
            state_nxt = ST_ACK;
          end
        end
        ST_ACK: begin
          tx_nxt    = 1'b1;
          state_nxt = ST_ACK_DEL;
        end
        ST_ACK_DEL: begin
          if (!rx) begin
            form_err_nxt = 1'b1;
            state_nxt    = ST_WAIT_IDLE;
          end else begin
            state_nxt = ST_EOF;
          end
        end
        ST_EOF: begin
          if (!rx) begin
            form_err_nxt = 1'b1;
            state_nxt    = ST_WAIT_IDLE;
          end else if (cnt == 6'(CAN_EOF_LEN - 1)) begin
            valid_nxt = frame_ok;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_WAIT_IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_WAIT_IDLE;
      cnt      <= '0;
      tx       <= 1'b1;
      rx_valid <= 1'b0;
      crc_err  <= 1'b0;
      form_err <= 1'b0;
      rx_id    <= '0;
      rx_data  <= '0;
      id_sh    <= '0;
      data_sh  <= '0;
      dlc_sh   <= '0;
      crc_rx   <= '0;
      frame_ok <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx       <= tx_nxt;
      rx_valid <= valid_nxt;
      crc_err  <= crc_err_nxt;
      form_err <= form_err_nxt;
      frame_ok <= ok_nxt;
      if (baud_tick) begin
        unique case (state)
          ST_ID:   id_sh   <= {rx, id_sh[10:1]};
          ST_DLC:  dlc_sh  <= {rx, dlc_sh[4:1]};
          ST_DATA: data_sh <= {rx, data_sh[31:1]};
          ST_CRC:  crc_rx  <= {rx, crc_rx[14:1]};
          default: ;
        endcase
      end
      // shadows only reach the outputs on a fully accepted frame
      if (valid_nxt) begin
        rx_id   <= id_sh;
        rx_data <= data_sh;
      end
    end
  end

endmodule

// File: tb/tb_can_rx.sv
// tb/tb_can_rx.sv - scoreboard bench for can_rx: good, CRC-error, form-error, reset and filter frames.
module tb_can_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        baud_tick = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [10:0] rx_id;
  logic [31:0] rx_data;
  logic        rx_valid, crc_err, form_err;
`ifdef CAN_RX_ID_FILTER_EN
  logic [10:0] acc_id = 11'h000;
  logic [10:0] acc_mask = 11'h000;
`endif

  can_rx dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
`ifdef CAN_RX_ID_FILTER_EN
    .acc_id    (acc_id),
    .acc_mask  (acc_mask),
`endif
    .tx        (tx),
    .rx_id     (rx_id),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .crc_err   (crc_err),
    .form_err  (form_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    int          bit_no;
    logic [10:0] id;
    logic [31:0] data;
  } exp_t;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_CRC   = 3'b010;
  localparam logic [2:0] K_FORM  = 3'b001;

  localparam int E_OK = 0, E_CRC = 1, E_FORM_DLC = 2, E_FORM_ACKDEL = 3, E_NONE = 4;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   bit_no = 0;
  int   gap = 3;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    bit_no++;
    rx = b;
    repeat (gap) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [10:0] id, input logic [4:0] dlc, input logic [31:0] data,
                            input logic [14:0] crc_xor, input bit ack_del, input int nbits,
                            input int outcome);
    bit          f[$];
    logic [15:0] r;
    logic [14:0] crc;
    bit          b;
    bit          ack;
    int          base;
    exp_t        e;
    f.push_back(1'b0);
    for (int i = 0; i < 11; i++) f.push_back(id[i]);
    for (int i = 0; i < 3; i++) f.push_back(1'b0);
    for (int i = 0; i < 5; i++) f.push_back(dlc[i]);
    for (int i = 0; i < 32; i++) f.push_back(data[i]);
    // remainder of message * x^15 divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
    r = 16'h0000;
    for (int i = 0; i < f.size() + 15; i++) begin
      b = (i < f.size()) ? f[i] : 1'b0;
      r = {r[14:0], b};
      if (r[15]) r = r ^ 16'hC599;
    end
    crc = r[14:0] ^ crc_xor;
    for (int i = 0; i < 15; i++) f.push_back(crc[i]);
    f.push_back(1'b1);
    f.push_back(1'b1);
    f.push_back(ack_del);
    for (int i = 0; i < 7; i++) f.push_back(1'b1);

    base   = bit_no + 1;
    e.id   = id;
    e.data = data;
    case (outcome)
      E_OK:          begin e.kind = K_VALID; e.bit_no = base + 76; exp_q.push_back(e); end
      E_CRC:         begin e.kind = K_CRC;   e.bit_no = base + 67; exp_q.push_back(e); end
      E_FORM_DLC:    begin e.kind = K_FORM;  e.bit_no = base + 19; exp_q.push_back(e); end
      E_FORM_ACKDEL: begin e.kind = K_FORM;  e.bit_no = base + 69; exp_q.push_back(e); end
      default: ;
    endcase
    ack = (outcome == E_OK) || (outcome == E_FORM_ACKDEL);

    for (int k = 0; k < nbits; k++) begin
      send_bit(f[k]);
      check_eq($sformatf("tx_bit%0d", k), tx, (ack && k == 67) ? 1'b0 : 1'b1);
    end
    check_eq("pending_events", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst && (rx_valid || crc_err || form_err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", {rx_valid, crc_err, form_err}, 3'b000);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("strobe_kind", {rx_valid, crc_err, form_err}, mon_e.kind);
        check_eq("strobe_bit", bit_no, mon_e.bit_no);
        if (mon_e.kind == K_VALID) begin
          check_eq("rx_id", rx_id, mon_e.id);
          check_eq("rx_data", rx_data, mon_e.data);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx"}, tx, 1'b1);
    check_eq({tag, "_valid"}, rx_valid, 1'b0);
    check_eq({tag, "_crc_err"}, crc_err, 1'b0);
    check_eq({tag, "_form_err"}, form_err, 1'b0);
    check_eq({tag, "_id"}, rx_id, 11'h000);
    check_eq({tag, "_data"}, rx_data, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    idle_bits(11);
    send_frame(11'h123, 5'd4, 32'hDEADBEEF, 15'h0, 1'b1, 77, E_OK);
    send_frame(11'h456, 5'd4, 32'h01234567, 15'h0001, 1'b1, 77, E_CRC);
    check_eq("hold_id_after_crc", rx_id, 11'h123);
    check_eq("hold_data_after_crc", rx_data, 32'hDEADBEEF);

    send_frame(11'h2A5, 5'd4, 32'hCAFEF00D, 15'h0, 1'b0, 77, E_FORM_ACKDEL);
    check_eq("hold_id_after_form", rx_id, 11'h123);
    idle_bits(11);

    send_frame(11'h123, 5'd3, 32'h55555555, 15'h0, 1'b1, 20, E_FORM_DLC);
    idle_bits(10);
    send_frame(11'h123, 5'd4, 32'h55555555, 15'h0, 1'b1, 77, E_NONE);
    idle_bits(11);
    send_frame(11'h7FF, 5'd4, 32'h00000001, 15'h0, 1'b1, 77, E_OK);

    send_frame(11'h0A0, 5'd4, 32'h12345678, 15'h0, 1'b1, 30, E_NONE);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    idle_bits(11);
    gap = 0;
    send_frame(11'h000, 5'd4, 32'hFFFF0000, 15'h0, 1'b1, 77, E_OK);
    send_frame(11'h3C3, 5'd4, 32'hA5A5A5A5, 15'h0, 1'b1, 77, E_OK);
    gap = 3;

`ifdef CAN_RX_ID_FILTER_EN
    acc_id   = 11'h120;
    acc_mask = 11'h7F0;
    send_frame(11'h12F, 5'd4, 32'h0BADBEEF, 15'h0, 1'b1, 77, E_OK);
    send_frame(11'h22F, 5'd4, 32'h11112222, 15'h0, 1'b1, 77, E_NONE);
    check_eq("filter_hold_id", rx_id, 11'h12F);
    send_frame(11'h12A, 5'd4, 32'h33334444, 15'h0, 1'b1, 77, E_OK);
`endif

    idle_bits(2);
    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_rx.md
# can_rx

Receive side of the CAN controller. Samples the serial bus once per bit period, decodes one fixed-format data frame (11-bit identifier, 4-byte payload, CRC-15), and drives the dominant ACK bit when the frame is good. It presents the decoded identifier and payload to the host logic with a one-cycle valid strobe. It sits next to `can_tx` on the same `rx` line and uses the same field order and bit order.

## Interface
- `IDLE_BITS`, default 11: number of consecutive recessive bits required before an SOF is accepted (bus integration).
- `DLC_VAL`, default 4: the only accepted data-length code.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `baud_tick` in 1: one-`clk` pulse at the bit sample point; the FSM advances only on cycles where this is high.
- `rx` in 1: CAN bus level; 1 is recessive, 0 is dominant.
- `tx` out 1: ACK drive; recessive (1) except in the ACK slot.
- `rx_id` out 11: identifier of the last accepted frame.
- `rx_data` out 32: payload of the last accepted frame.
- `rx_valid` out 1: one-cycle strobe marking a new accepted frame.
- `crc_err` out 1: one-cycle strobe for a CRC mismatch.
- `form_err` out 1: one-cycle strobe for a fixed-field violation.

## Operation
- Frame format, all multi-bit fields sent LSB first, no bit stuffing:
  - SOF = 0
  - ID: 11 bits
  - RTR = 0, IDE = 0, r0 = 0
  - DLC: 5 bits
  - DATA: 32 bits
  - CRC: 15 bits
  - CRC delimiter = 1, ACK slot, ACK delimiter = 1
  - EOF: 7 × 1
- FSM states: WAIT_IDLE, IDLE, ID, CTRL, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF.
- Transitions, all evaluated on `baud_tick`:
  - WAIT_IDLE: counts recessive bits; any dominant bit clears the count. After `IDLE_BITS` recessive bits, go to IDLE.
  - IDLE: a sampled 0 is SOF → ID.
  - ID (11 bits) → CTRL (3 bits, each must be 0) → DLC (5 bits, value must equal `DLC_VAL`, checked on the last bit) → DATA (32 bits) → CRC (15 bits) → CRC_DEL → ACK → ACK_DEL → EOF (7 bits) → IDLE.
- Bit counter: 6 bits wide, cleared on every state change.
- CRC-15, polynomial 0x4599, initial value 0:
  - Covers SOF through the last DATA bit.
  - Received CRC bits shift into a separate 15-bit register, LSB first.
  - CRC is compared when CRC_DEL is sampled.
- Form error, on any of: nonzero CTRL bit, DLC ≠ `DLC_VAL`, 0 sampled in CRC_DEL, ACK_DEL or any EOF bit. Response: pulse `form_err`, drop the frame, go to WAIT_IDLE.
- CRC mismatch: pulse `crc_err` when CRC_DEL is sampled. `tx` stays recessive in the ACK slot. The FSM continues through EOF but `rx_valid` is not raised.
- ACK slot level is not checked; a lone receiver sees its own dominant bit.
- Accept: `rx_id` and `rx_data` load, and `rx_valid` pulses, on the tick that samples the 7th EOF bit. Outputs hold until the next accept.
- Shadow registers capture ID and DATA during the frame, so `rx_id`/`rx_data` do not change on a rejected frame.

## Timing
- Reset values:
  - `tx` = 1; `rx_valid`, `crc_err`, `form_err` = 0; `rx_id` = 0; `rx_data` = 0.
  - FSM in WAIT_IDLE, counters and CRC cleared.
- Reset mid-frame: the frame is discarded with no strobes, and `IDLE_BITS` recessive bits are needed again.
- All outputs are registered. A strobe is high for exactly the one `clk` cycle after the qualifying `baud_tick` edge.
- `tx`:
  - Goes to 0 on the `clk` edge that samples CRC_DEL = 1, provided the CRC matches and the frame is accepted.
  - Returns to 1 on the edge that samples the ACK slot, giving one full bit time of dominant drive.
- Latency: `rx_valid` is high one `clk` after the `baud_tick` of the last EOF bit.
- `rx` is sampled only on `baud_tick`; no edge resynchronisation inside this block.
- `baud_tick` held high continuously is legal: one bit per `clk`.

## Configuration
- `CAN_RX_ID_FILTER_EN` defined:
  - Adds inputs `acc_id[10:0]` and `acc_mask[10:0]`.
  - A frame passes when `(id ^ acc_id) & acc_mask == 0`.
  - A failing frame gets no ACK and no `rx_valid`; no error is raised and the FSM still tracks the frame to EOF.
- `CAN_RX_ID_FILTER_EN` undefined: ports absent; every error-free frame is accepted.

## Structure
- Package `can_pkg`:
  - FSM state enum, shared with the `can_tx` encoding.
  - Field-length constants: ID 11, CTRL 3, DLC 5, DATA 32, CRC 15, EOF 7.
  - `CAN_CRC_POLY` = 15'h4599.
- Sub-module `can_crc15`: serial CRC with `clk`, `rst`, `en`, `clr`, `din`, `crc[14:0]`. The same unit serves the transmitter.

## Test plan
- Good frame: ID 0x123, data 0xDEADBEEF, CRC from the reference model → `tx` low for exactly the ACK bit; `rx_valid` one cycle; `rx_id` = 0x123, `rx_data` = 0xDEADBEEF.
- CRC bit 0 flipped → `crc_err` pulse at CRC_DEL; no ACK; no `rx_valid`; `rx_id`/`rx_data` keep their previous values.
- DLC = 3 → `form_err` on the last DLC bit; the next SOF is ignored until 11 recessive bits have passed.
- ACK delimiter forced to 0 → `form_err`; no `rx_valid`.
- `rst` asserted in the middle of DATA → all outputs at reset values; a back-to-back frame sent after 11 idle bits is received correctly.
- With `CAN_RX_ID_FILTER_EN`, `acc_id` = 0x120, `acc_mask` = 0x7F0: ID 0x12F is accepted; ID 0x22F gives no ACK and no strobe.
